// File: rtl/rstseq_if.sv
// Request/status bundle between devtbl/multipu and the reset sequencer.
interface rstseq_if #(
  parameter int unsigned DOMAINCNT = 4
);
  logic                 rst0_i;
  logic                 rst1_i;
  logic                 purst_i;
  logic [DOMAINCNT-1:0] rst_o;
  logic                 busy_o;
  logic                 pwroff_o;
  logic [1:0]           cause_o;

  modport master (
    output rst0_i, rst1_i, purst_i,
    input  rst_o, busy_o, pwroff_o, cause_o
  );

  modport slave (
    input  rst0_i, rst1_i, purst_i,
    output rst_o, busy_o, pwroff_o, cause_o
  );
endinterface

// File: rtl/rstseq.sv
// Multi-domain reset sequencer: decodes sw/PU reset requests, holds all targeted
// domains for a fixed count, then releases them one by one in index order.
module rstseq #(
  parameter int unsigned          DOMAINCNT = 4,
  parameter int unsigned          CNTRBITSZ = 4,
  parameter int unsigned          STAGEGAP  = 2,
  parameter logic [DOMAINCNT-1:0] WARMMASK  = '1
) (
  input logic     clk_i,
  input logic     rst_i,
  rstseq_if.slave bus
);
  localparam int unsigned STAGEW = (DOMAINCNT > 1) ? $clog2(DOMAINCNT) : 1;
  localparam int unsigned GAPW   = (STAGEGAP > 0) ? $clog2(STAGEGAP + 1) : 1;
  localparam logic [STAGEW-1:0] LASTSTAGE = STAGEW'(DOMAINCNT - 1);
  localparam logic [GAPW-1:0]   GAPLOAD   = GAPW'(STAGEGAP);

  typedef enum logic [1:0] {IDLE, HOLD, RELEASE, OFF} state_e;

  state_e               state_q, state_d;
  logic [CNTRBITSZ-1:0] cntr_q, cntr_d;
  logic [GAPW-1:0]      gap_q, gap_d;
  logic [STAGEW-1:0]    stage_q, stage_d;
  logic [DOMAINCNT-1:0] rst_q, rst_d;
  logic                 busy_q, busy_d;
  logic                 pwroff_q, pwroff_d;
  logic [1:0]           cause_q, cause_d;

  logic req_off, req_cold, req_warm, req_pu, accept;

  assign req_off  = ~bus.rst1_i &  bus.rst0_i;
  assign req_cold =  bus.rst1_i &  bus.rst0_i;
  assign req_warm =  bus.rst1_i & ~bus.rst0_i;
  assign req_pu   =  bus.purst_i;
  assign accept   = (state_q != OFF);

  always_comb begin
    state_d  = state_q;
    cntr_d   = cntr_q;
    gap_d    = gap_q;
    stage_d  = stage_q;
    rst_d    = rst_q;
    pwroff_d = pwroff_q;
    cause_d  = cause_q;

    // Requests are levels: while one is held the hold counter stays reloaded.
    if (accept && req_off) begin
      state_d  = OFF;
      rst_d    = '1;
      pwroff_d = 1'b1;
    end else if (accept && req_cold) begin
      state_d = HOLD;
      rst_d   = '1;
      cntr_d  = '1;
      stage_d = '0;
      gap_d   = '0;
      cause_d = 2'b10;
    end else if (accept && (req_warm || req_pu)) begin
      state_d = HOLD;
      rst_d   = rst_q | WARMMASK;
      cntr_d  = '1;
      stage_d = '0;
      gap_d   = '0;
      cause_d = req_warm ? 2'b01 : 2'b11;
    end else begin
      case (state_q)
        HOLD: begin
          if (cntr_q != '0) begin
            cntr_d = cntr_q - 1'b1;
          end else begin
            rst_d[0] = 1'b0;
            if (DOMAINCNT == 1) begin
              state_d = IDLE;
            end else begin
              gap_d   = GAPLOAD;
              stage_d = STAGEW'(1);
              state_d = RELEASE;
            end
          end
        end
        RELEASE: begin
          if (gap_q != '0) begin
            gap_d = gap_q - 1'b1;
          end else begin
            // Domains already clear still use their slot, keeping timing cause-independent.
            rst_d[stage_q] = 1'b0;
            gap_d          = GAPLOAD;
            if (stage_q == LASTSTAGE) begin
              stage_d = '0;
              state_d = IDLE;
            end else begin
              stage_d = stage_q + 1'b1;
            end
          end
        end
        IDLE:    rst_d = '0;
        OFF:     ;
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= HOLD;
      cntr_q   <= '1;
      gap_q    <= '0;
      stage_q  <= '0;
      rst_q    <= '1;
      busy_q   <= 1'b1;
      pwroff_q <= 1'b0;
      cause_q  <= 2'b00;
    end else begin
      state_q  <= state_d;
      cntr_q   <= cntr_d;
      gap_q    <= gap_d;
      stage_q  <= stage_d;
      rst_q    <= rst_d;
      busy_q   <= busy_d;
      pwroff_q <= pwroff_d;
      cause_q  <= cause_d;
    end
  end

  assign bus.rst_o    = rst_q;
  assign bus.busy_o   = busy_q;
  assign bus.pwroff_o = pwroff_q;
  assign bus.cause_o  = cause_q;
endmodule

// File: tb/tb_rstseq.sv
// Scoreboard bench for rstseq: stimulus queues per-edge expectations, a negedge
// monitor pops and compares them against the sequencer outputs.
module tb_rstseq;
  localparam int unsigned DOMAINCNT = 4;

  typedef struct {
    int unsigned key;
    logic [3:0]  r;
    logic        b;
    logic        p;
    logic [1:0]  c;
    string       name;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  int unsigned cyc   = 0;
  int unsigned nvec  = 0;
  int unsigned nerr  = 0;
  int unsigned base;
  exp_t        sb[$];

  rstseq_if #(.DOMAINCNT(DOMAINCNT)) bus ();

  rstseq #(
    .DOMAINCNT(DOMAINCNT),
    .CNTRBITSZ(4),
    .STAGEGAP (2),
    .WARMMASK (4'b0110)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .bus  (bus)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [3:0] er, input logic eb,
                       input logic ep, input logic [1:0] ec);
    nvec++;
    if (bus.rst_o !== er || bus.busy_o !== eb || bus.pwroff_o !== ep || bus.cause_o !== ec) begin
      nerr++;
      $display("FAIL %s @cyc %0d: got rst=%b busy=%b pwroff=%b cause=%b, want rst=%b busy=%b pwroff=%b cause=%b",
               name, cyc, bus.rst_o, bus.busy_o, bus.pwroff_o, bus.cause_o, er, eb, ep, ec);
    end
  endtask

  task automatic push(input int unsigned key, input logic [3:0] r, input logic b,
                      input logic p, input logic [1:0] c, input string name);
    exp_t e;
    e.key = key; e.r = r; e.b = b; e.p = p; e.c = c; e.name = name;
    sb.push_back(e);
  endtask

  // Domain k released at counted edge 16 + 3k; busy drops with the last slot at 25.
  task automatic push_seq(input int unsigned b0, input int unsigned nmax,
                          input logic [3:0] mask, input logic [1:0] c, input string name);
    logic [3:0] r;
    for (int unsigned n = 1; n <= nmax; n++) begin
      for (int k = 0; k < 4; k++) r[k] = mask[k] && (n < 16 + 3 * k);
      push(b0 + n, r, (n < 25), 1'b0, c, name);
    end
  endtask

  task automatic hold(input int unsigned ncyc, input logic [3:0] r, input logic p,
                      input logic [1:0] c, input string name);
    for (int unsigned i = 0; i < ncyc; i++) begin
      push(cyc + 1, r, 1'b1, p, c, name);
      @(posedge clk_i); #1;
    end
  endtask

  always @(negedge clk_i) begin : monitor
    exp_t e;
    while (sb.size() != 0 && sb[0].key <= cyc) begin
      e = sb.pop_front();
      if (e.key < cyc) begin
        nvec++;
        nerr++;
        $display("FAIL %s: expectation for cyc %0d not checked (now cyc %0d)", e.name, e.key, cyc);
      end else begin
        check(e.name, e.r, e.b, e.p, e.c);
      end
    end
  end

  initial begin
    bus.rst0_i  = 1'b0;
    bus.rst1_i  = 1'b0;
    bus.purst_i = 1'b0;
    rst_i       = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    check("reset_state", 4'b1111, 1'b1, 1'b0, 2'b00);

    // External reset release, full default sequence.
    rst_i = 1'b0;
    base  = cyc;
    push_seq(base, 30, 4'b1111, 2'b00, "ext_seq");
    repeat (30) @(posedge clk_i);
    #1;

    // Warm from idle: only WARMMASK domains reasserted.
    bus.rst1_i = 1'b1;
    hold(3, 4'b0110, 1'b0, 2'b01, "warm_hold");
    bus.rst1_i = 1'b0;
    base = cyc;
    push_seq(base, 30, 4'b0110, 2'b01, "warm_seq");
    repeat (30) @(posedge clk_i);
    #1;

    // Cold, then cold again mid-RELEASE after domain 1 released.
    bus.rst1_i = 1'b1;
    bus.rst0_i = 1'b1;
    hold(1, 4'b1111, 1'b0, 2'b10, "cold_hold");
    bus.rst1_i = 1'b0;
    bus.rst0_i = 1'b0;
    base = cyc;
    push_seq(base, 20, 4'b1111, 2'b10, "cold_seq1");
    repeat (20) @(posedge clk_i);
    #1;
    bus.rst1_i = 1'b1;
    bus.rst0_i = 1'b1;
    hold(2, 4'b1111, 1'b0, 2'b10, "cold_restart");
    bus.rst1_i = 1'b0;
    bus.rst0_i = 1'b0;
    base = cyc;
    push_seq(base, 30, 4'b1111, 2'b10, "cold_seq2");
    repeat (30) @(posedge clk_i);
    #1;

    // Power-off, then cold+PU ignored, exit only through rst_i.
    bus.rst0_i = 1'b1;
    hold(1, 4'b1111, 1'b1, 2'b10, "pwroff_enter");
    bus.rst1_i  = 1'b1;
    bus.purst_i = 1'b1;
    hold(100, 4'b1111, 1'b1, 2'b10, "off_ignore");
    @(negedge clk_i);
    #2;
    rst_i = 1'b1;
    #1;
    check("pwroff_async_clear", 4'b1111, 1'b1, 1'b0, 2'b00);
    bus.rst0_i  = 1'b0;
    bus.rst1_i  = 1'b0;
    bus.purst_i = 1'b0;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    base  = cyc;
    push_seq(base, 30, 4'b1111, 2'b00, "post_off_seq");
    repeat (30) @(posedge clk_i);
    #1;

    // Warm+PU together, then PU alone held 10 cycles.
    bus.rst1_i  = 1'b1;
    bus.purst_i = 1'b1;
    hold(2, 4'b0110, 1'b0, 2'b01, "warm_pu");
    bus.rst1_i = 1'b0;
    hold(10, 4'b0110, 1'b0, 2'b11, "pu_hold");
    bus.purst_i = 1'b0;
    base = cyc;
    push_seq(base, 20, 4'b0110, 2'b11, "pu_seq");
    repeat (20) @(posedge clk_i);

    // External reset between edges during RELEASE.
    @(negedge clk_i);
    #2;
    rst_i = 1'b1;
    #1;
    check("async_mid_release", 4'b1111, 1'b1, 1'b0, 2'b00);
    @(posedge clk_i);
    #1;
    check("rst_held", 4'b1111, 1'b1, 1'b0, 2'b00);
    rst_i = 1'b0;
    base  = cyc;
    push_seq(base, 30, 4'b1111, 2'b00, "async_restart_seq");
    repeat (30) @(posedge clk_i);

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk_i);
    #1;
    if (sb.size() != 0) begin
      nvec++;
      nerr++;
      $display("FAIL drain: %0d expectations left unchecked", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/rstseq.md
Name: rstseq

Overview:
- Parametrised reset sequencer for multi-domain SoC tops.
- Generalises the single-counter reset-stretch logic into DOMAINCNT reset domains. Each domain has its own active-high reset output, released one after another in index order.
- Decodes the device-table software reset pair (cold/warm/power-off) and the PU-requested reset. Reports the last reset cause and a sticky power-off flag.
- Sits at the top level, between devtbl/multipu and every reset consumer.

Parameters:
DOMAINCNT, 4, number of reset domains; domain 0 is released first.
CNTRBITSZ, 4, hold-counter width; hold length is (2**CNTRBITSZ)-1 cycles.
STAGEGAP, 2, extra cycles between consecutive domain releases; domain k+1 is released STAGEGAP+1 edges after domain k.
WARMMASK, {DOMAINCNT{1'b1}}, domains reasserted by a warm or PU reset; bits at 0 are untouched by warm/PU.

Ports:
clk_i  in  1  clock.
rst_i  in  1  external reset; asynchronous, active-high.
rst0_i  in  1  devtbl rst0.
rst1_i  in  1  devtbl rst1. {rst1_i,rst0_i} decodes as: 00 none, 01 power-off, 10 warm, 11 cold.
purst_i  in  1  PU-requested reset (multipu rst_o); level.
rst_o  out  DOMAINCNT  per-domain reset, active-high.
busy_o  out  1  high while the sequencer is not IDLE.
pwroff_o  out  1  sticky power-off indication.
cause_o  out  2  cause of the last reset: 00 ext, 01 sw warm, 10 sw cold, 11 PU.

Behaviour:
- Registers: state (IDLE/HOLD/RELEASE/OFF), cntr[CNTRBITSZ], gap counter sized for STAGEGAP, stage index of width clog2(DOMAINCNT) (min 1 bit), rst_o, pwroff_o, cause_o. All are flops; all outputs are registered.
- rst_i high, asynchronously: state=HOLD, cntr=all ones, rst_o=all ones, pwroff_o=0, cause_o=00, stage=0, gap=0; busy_o=1.
- Request priority, evaluated every edge except in OFF: power-off > cold > warm > PU.
- Power-off (01): state=OFF, rst_o=all ones, pwroff_o=1.
  - OFF is exited only by rst_i. All requests are ignored in OFF.
- Cold (11): rst_o=all ones, cntr=all ones, stage=0, state=HOLD, cause_o=10.
- Warm (10) or purst_i:
  - rst_o |= WARMMASK; cntr=all ones, stage=0, state=HOLD.
  - cause_o=01 for warm, else 11. If warm and PU occur together, cause is 01.
- Requests are levels. Any accepted request re-triggers from any state (IDLE/HOLD/RELEASE), so the hold count starts only after the request drops.
  - Example: a cold request during a warm RELEASE reasserts all domains.
- HOLD: if cntr!=0, decrement. Else clear rst_o[0], set gap=STAGEGAP, stage=1, state=RELEASE.
  - If DOMAINCNT==1, go directly to IDLE.
- RELEASE: if gap!=0, decrement. Else clear rst_o[stage], reload gap, increment stage.
  - Clearing the last index goes to IDLE.
  - Already-clear domains (outside WARMMASK) still consume their slot, so timing is identical for every cause.
- IDLE: rst_o=0, busy_o=0. Outputs hold until the next request.
- busy_o is high in HOLD, RELEASE and OFF. It falls on the same edge the last domain is released.
- Latency, counting edges from the first rising edge with rst_i low and no request:
  - domain k released at edge 2**CNTRBITSZ + k*(STAGEGAP+1).
  - defaults: edges 16, 19, 22, 25.
- rst_i deasserting asynchronously mid-cycle needs no synchronizer here. Consumers synchronise as needed; the first counted edge is the first edge that samples rst_i low.
- Out-of-range stage index is never produced (stage < DOMAINCNT enforced).

Test Plan:
- Defaults. Pulse rst_i, then release. -> rst_o=4'b1111 until edge 15; 4'b1110 at edge 16, 4'b1100 at 19, 4'b1000 at 22, 4'b0000 at 25; busy_o falls at 25; cause_o=00.
- WARMMASK=4'b0110, idle. Hold {rst1,rst0}=10 for 3 cycles. -> rst_o=4'b0110 the edge after the request; bit1 clears 16+3 edges after the request drops, bit2 at +6; bits 0 and 3 stay 0 throughout; cause_o=01.
- Cold request during RELEASE (after domain 1 released). -> rst_o=4'b1111 on the next edge, full sequence restarts; cause_o=10.
- Power-off (01) while idle. -> rst_o=4'b1111, pwroff_o=1, busy_o=1. A subsequent cold request and purst_i are ignored for 100 cycles. Assert rst_i -> pwroff_o=0 asynchronously, normal sequence follows.
- purst_i and warm together, then purst_i alone. -> cause_o=01, then 11. Purst held 10 cycles delays domain 0 release to edge 16 after the drop.
- rst_i asserted mid-RELEASE, between clock edges. -> rst_o=all ones immediately without a clock edge; cause_o=00; the sequence restarts.
